// File: rtl/hmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hmem_arbiter_if
// Desc     : Bundles the icache, dcache and downstream hmem word-transaction
//            signals that meet at hmem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface hmem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_rdata;
    logic            i_done;

    logic            d_valid;
    logic            d_op;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_done;

    logic            hmem_valid;
    logic            hmem_op;
    logic [XLEN-1:0] hmem_addr;
    logic [XLEN-1:0] hmem_wdata;
    logic [XLEN-1:0] hmem_rdata;
    logic            hmem_done;

    // Arbiter side
    modport slave (
        input  i_valid, i_addr,
        output i_rdata, i_done,
        input  d_valid, d_op, d_addr, d_wdata,
        output d_rdata, d_done,
        output hmem_valid, hmem_op, hmem_addr, hmem_wdata,
        input  hmem_rdata, hmem_done
    );

    // Environment side: both cache controllers and the downstream memory
    modport master (
        output i_valid, i_addr,
        input  i_rdata, i_done,
        output d_valid, d_op, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  hmem_valid, hmem_op, hmem_addr, hmem_wdata,
        output hmem_rdata, hmem_done
    );
endinterface
`default_nettype wire

// File: rtl/hmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hmem_arbiter
// Desc     : Shares one hmem port between icache and dcache, granting whole lines
//            (BEATS words). Define HMEM_ARB_DCACHE_PRIORITY_EN for dcache-wins ties.
// Revision : 1.0  initial release
// ============================================================================
module hmem_arbiter #(
    parameter int LINE_SIZE = 32,
    parameter int XLEN      = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hmem_arbiter_if.slave bus
);
    localparam int            BEATS      = LINE_SIZE * 8 / XLEN;
    localparam int            CW         = $clog2(BEATS);
    localparam logic [CW-1:0] c_LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_beat_cnt_nxt;
    logic          w_pick_i;
    logic          w_pick_d;
    logic          w_own_valid;

`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
    assign w_pick_d = bus.d_valid;
    assign w_pick_i = bus.i_valid & ~bus.d_valid;
`else
    logic r_rr_last;  // 1: dcache won the most recent grant

    assign w_pick_i = bus.i_valid & (~bus.d_valid | r_rr_last);
    assign w_pick_d = bus.d_valid & ~w_pick_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (r_state == IDLE && (w_pick_i || w_pick_d)) begin
            r_rr_last <= w_pick_d;
        end
    end
`endif

    assign w_own_valid = (r_state == GRANT_I) ? bus.i_valid : bus.d_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        bus.hmem_valid = 1'b0;
        bus.hmem_op    = 1'b0;
        bus.hmem_addr  = '0;
        bus.hmem_wdata = '0;
        bus.i_rdata    = '0;
        bus.i_done     = 1'b0;
        bus.d_rdata    = '0;
        bus.d_done     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_i) begin
                    w_state_nxt    = GRANT_I;
                    w_beat_cnt_nxt = c_LAST_CNT;
                end else if (w_pick_d) begin
                    w_state_nxt    = GRANT_D;
                    w_beat_cnt_nxt = c_LAST_CNT;
                end
            end
            GRANT_I: begin
                bus.hmem_valid = bus.i_valid;
                bus.hmem_addr  = bus.i_addr;
                bus.i_rdata    = bus.hmem_rdata;
                bus.i_done     = bus.hmem_done;
            end
            GRANT_D: begin
                bus.hmem_valid = bus.d_valid;
                bus.hmem_op    = bus.d_op;
                bus.hmem_addr  = bus.d_addr;
                bus.hmem_wdata = bus.d_wdata;
                bus.d_rdata    = bus.hmem_rdata;
                bus.d_done     = bus.hmem_done;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Line bookkeeping; a dropped valid with no completing word ends the grant
        if (r_state == GRANT_I || r_state == GRANT_D) begin
            if (bus.hmem_done) begin
                if (r_beat_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt - 1'b1;
                end
            end else if (!w_own_valid) begin
                w_state_nxt = IDLE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hmem_arbiter.sv
`default_nettype none
// Bench for hmem_arbiter: directed scenarios plus randomized line traffic,
// checked cycle by cycle against a line-ownership reference model.
module tb_hmem_arbiter;
    localparam int LINE_SIZE = 32;
    localparam int XLEN      = 32;
    localparam int BEATS     = LINE_SIZE * 8 / XLEN;
`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
    localparam int FIRST_TIE = 2;
    localparam int NEXT_TIE  = 2;
`else
    localparam int FIRST_TIE = 1;
    localparam int NEXT_TIE  = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hmem_arbiter_if #(.XLEN(XLEN)) bus ();

    hmem_arbiter #(
        .LINE_SIZE (LINE_SIZE),
        .XLEN      (XLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    bit          job_act   [2];
    logic [31:0] job_base  [2];
    int          job_idx   [2];
    bit          job_op    [2];
    logic [31:0] job_wd    [2];
    int          job_abort [2];

    // Reference model: current line owner (0 none, 1 icache, 2 dcache),
    // words left in the granted line, and who won the last grant.
    int m_owner, m_left, m_last;
    int grants[$];
    int done_mode, cyc, n_idone, n_ddone;
    bit stray_en;
    logic        obs_hv, obs_op;
    logic [31:0] obs_addr, obs_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag,
                                 input logic hv, input logic op,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic idn, input logic [31:0] ird,
                                 input logic ddn, input logic [31:0] drd);
        chk({tag, ".hmem_valid"}, 32'(bus.hmem_valid), 32'(hv));
        chk({tag, ".hmem_op"},    32'(bus.hmem_op),    32'(op));
        chk({tag, ".hmem_addr"},  bus.hmem_addr,       addr);
        chk({tag, ".hmem_wdata"}, bus.hmem_wdata,      wd);
        chk({tag, ".i_done"},     32'(bus.i_done),     32'(idn));
        chk({tag, ".i_rdata"},    bus.i_rdata,         ird);
        chk({tag, ".d_done"},     32'(bus.d_done),     32'(ddn));
        chk({tag, ".d_rdata"},    bus.d_rdata,         drd);
    endtask

    function automatic logic [31:0] job_addr(input int x);
        return job_base[x] + 32'(job_idx[x] * 4);
    endfunction

    task automatic start_job(input int x, input logic [31:0] base, input bit op,
                             input logic [31:0] wd, input int abort_at);
        job_act[x]   = 1'b1;
        job_base[x]  = base;
        job_idx[x]   = 0;
        job_op[x]    = op;
        job_wd[x]    = wd;
        job_abort[x] = abort_at;
    endtask

    task automatic cycle();
        logic        iv, dv, dop, hd, req;
        logic [31:0] ia, da, dwd, rd;
        int          win;
        @(negedge clk);
        iv  = job_act[0];
        dv  = job_act[1];
        ia  = iv ? job_addr(0) : 32'h0;
        da  = dv ? job_addr(1) : 32'h0;
        dop = dv & job_op[1];
        dwd = dv ? job_wd[1] : 32'h0;
        bus.i_valid = iv;  bus.i_addr = ia;
        bus.d_valid = dv;  bus.d_op = dop;  bus.d_addr = da;  bus.d_wdata = dwd;

        // Downstream memory: completes only words that are really requested
        req = (m_owner == 1 && iv) || (m_owner == 2 && dv);
        if (req) begin
            case (done_mode)
                1:       hd = (cyc % 3 == 2);
                default: hd = ($urandom_range(0, 2) == 0);
            endcase
        end else begin
            hd = (m_owner == 0) && stray_en && (cyc % 2 == 1);
        end
        if (req && !(m_owner == 2 && dop)) rd = mem[(m_owner == 1) ? ia[9:2] : da[9:2]];
        else                               rd = $urandom;
        bus.hmem_done  = hd;
        bus.hmem_rdata = rd;
        #1;

        case (m_owner)
            1:       check_outputs("granted_i", iv, 1'b0, ia, 32'h0, hd, rd, 1'b0, 32'h0);
            2:       check_outputs("granted_d", dv, dop, da, dwd, 1'b0, 32'h0, hd, rd);
            default: check_outputs("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        endcase
        obs_hv = bus.hmem_valid;  obs_op = bus.hmem_op;
        obs_addr = bus.hmem_addr; obs_wd = bus.hmem_wdata;
        n_idone += int'(bus.i_done);
        n_ddone += int'(bus.d_done);

        if (hd && m_owner == 2 && dop) mem[da[9:2]] = dwd;
        for (int x = 0; x < 2; x++) begin
            if (hd && m_owner == x + 1) begin
                job_idx[x]++;
                if (job_idx[x] == BEATS || job_idx[x] == job_abort[x]) job_act[x] = 1'b0;
            end
        end

        if (m_owner == 0) begin
            if (iv && dv) begin
`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
                win = 2;
`else
                win = (m_last == 2) ? 1 : 2;
`endif
            end else if (iv) win = 1;
            else if (dv)     win = 2;
            else             win = 0;
            if (win != 0) begin
                m_owner = win;  m_left = BEATS;  m_last = win;
                grants.push_back(win);
            end
        end else if (hd) begin
            m_left--;
            if (m_left == 0) m_owner = 0;
        end else if (!req) begin
            m_owner = 0;
        end
        cyc++;
    endtask

    // Asynchronous reset in the middle of a cycle with a completion in flight
    task automatic reset_now();
        @(negedge clk);
        #2;
        bus.hmem_done  = 1'b1;
        bus.hmem_rdata = 32'hA5A5_A5A5;
        rst = 1'b1;
        #1;
        check_outputs("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;  bus.d_valid = 1'b0;  bus.hmem_done = 1'b0;
        rst = 1'b0;
        job_act[0] = 1'b0;  job_act[1] = 1'b0;
        m_owner = 0;  m_left = 0;  m_last = 2;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((job_act[0] || job_act[1] || m_owner != 0) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n >= limit), 32'd0);
    endtask

    initial begin
        bus.i_valid = 1'b0;  bus.i_addr = '0;
        bus.d_valid = 1'b0;  bus.d_op = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus.hmem_done = 1'b0;  bus.hmem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        m_owner = 0;  m_left = 0;  m_last = 2;
        done_mode = 0;  stray_en = 1'b0;  cyc = 0;

        // 1: single icache line, completion every third cycle
        reset_now();
        grants.delete();  n_idone = 0;  done_mode = 1;
        start_job(0, 32'h100, 1'b0, 32'h0, -1);
        cycle();
        chk("t1_idle_first", 32'(obs_hv), 32'd0);
        cycle();
        chk("t1_valid_latency", 32'(obs_hv), 32'd1);
        chk("t1_addr_latency", obs_addr, 32'h100);
        run_until_idle(100);
        chk("t1_i_done_count", 32'(n_idone), 32'd8);
        chk("t1_grant", 32'(grants[0]), 32'd1);

        // 2: simultaneous requests after reset, then a second tie
        reset_now();
        grants.delete();  done_mode = 0;
        start_job(0, 32'h040, 1'b0, 32'h0, -1);
        start_job(1, 32'h180, 1'b0, 32'h0, -1);
        run_until_idle(300);
        chk("t2_grant_count", 32'(grants.size()), 32'd2);
        chk("t2_first_winner", 32'(grants[0]), 32'(FIRST_TIE));
        chk("t2_second_winner", 32'(grants[1]), 32'(3 - FIRST_TIE));
        start_job(0, 32'h0C0, 1'b0, 32'h0, -1);
        start_job(1, 32'h1C0, 1'b0, 32'h0, -1);
        run_until_idle(300);
        chk("t2_next_tie", 32'(grants[2]), 32'(NEXT_TIE));

        // 3: dcache writeback line
        n_idone = 0;  n_ddone = 0;
        start_job(1, 32'h200, 1'b1, 32'hDEAD_BEEF, -1);
        cycle();
        cycle();
        chk("t3_op", 32'(obs_op), 32'd1);
        chk("t3_wdata", obs_wd, 32'hDEAD_BEEF);
        run_until_idle(200);
        chk("t3_i_done_count", 32'(n_idone), 32'd0);
        chk("t3_d_done_count", 32'(n_ddone), 32'd8);

        // 4: reset while the dcache is on beat 3, icache pending
        done_mode = 1;
        start_job(1, 32'h300, 1'b0, 32'h0, -1);
        start_job(0, 32'h380, 1'b0, 32'h0, -1);
        for (int n = 0; n < 100 && job_idx[1] < 3; n++) cycle();
        chk("t4_reached_beat3", 32'(job_idx[1]), 32'd3);
        reset_now();
        grants.delete();  done_mode = 0;
        start_job(0, 32'h000, 1'b0, 32'h0, -1);
        start_job(1, 32'h020, 1'b0, 32'h0, -1);
        cycle();
        chk("t4_tie_after_reset", 32'(grants[0]), 32'(FIRST_TIE));
        run_until_idle(300);

        // 5: stray completions while idle, then an early-aborting requester
        stray_en = 1'b1;  n_idone = 0;  n_ddone = 0;
        repeat (12) cycle();
        chk("t5_stray_done_count", 32'(n_idone + n_ddone), 32'd0);
        stray_en = 1'b0;
        start_job(0, 32'h080, 1'b0, 32'h0, 2);
        run_until_idle(100);
        chk("t5_abort_done_count", 32'(n_idone), 32'd2);
        chk("t5_abort_idle", 32'(obs_hv), 32'd0);

`ifdef HMEM_ARB_DCACHE_PRIORITY_EN
        // 6: dcache wins every tie across back-to-back lines
        grants.delete();
        start_job(0, 32'h240, 1'b0, 32'h0, -1);
        for (int k = 0; k < 3; k++) begin
            start_job(1, 32'h260 + 32'(k * 32), 1'b0, 32'h0, -1);
            for (int n = 0; n < 200 && job_act[1]; n++) cycle();
        end
        chk("t6_grant_count", 32'(grants.size()), 32'd3);
        for (int k = 0; k < 3; k++) chk("t6_dcache_wins", 32'(grants[k]), 32'd2);
        chk("t6_icache_waiting", 32'(job_idx[0]), 32'd0);
        run_until_idle(100);
`endif

        // Randomized line traffic with aborts and stray completions
        stray_en = 1'b1;
        repeat (600) begin
            for (int x = 0; x < 2; x++) begin
                if (!job_act[x] && $urandom_range(0, 5) == 0)
                    start_job(x, {22'h0, 5'($urandom_range(0, 31)), 5'h0},
                              (x == 1) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom,
                              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, BEATS - 1)) : -1);
            end
            cycle();
        end
        run_until_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
